bram_port_arbiter: RTL and testbench

Shares the single read/write port B of the frame BRAM between two requesters: the VGA scan-out stream and an image-processing engine (PE) that reads and writes pixels. VGA reads have priority. Each accepted access is registered onto the BRAM port, and read data is returned to the owning requester after a fixed latency. The block sits between the VGA timing/address logic and PE on one side and the BRAM on the other.

---
 rtl/bram_port_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_bram_port_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// bram_port_arbiter
//
// Shares port B of the frame BRAM between the VGA scan-out stream and the
// image-processing engine (PE). VGA reads have priority. The winning access
// of each cycle is registered onto the BRAM port. Read data is returned to
// whichever requester issued the read, RD_LAT cycles after the BRAM enable.
//
// Optional build macro:
//   ARB_STARVE_GUARD_EN  builds a starvation counter. After STARVE_MAX
//                        consecutive denied PE cycles, PE is forced through
//                        and the displaced VGA request is reported as a drop.
//                        Without it, VGA has strict priority and the drop
//                        outputs are tied to 0.
//
// Parameters:
//   ADDR_W      BRAM address width
//   DATA_W      pixel width
//   RD_LAT      BRAM read latency (enable to data valid on mem2db_i), >= 1
//   STARVE_MAX  denied PE cycles before PE is forced (guard build only)
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   vga_req_i/addr_i    VGA read request and address, one read per cycle
//   vga_data_o/valid_o  returned VGA pixel (0 while not valid)
//   vga_drop_o          registered pulse: a VGA request was displaced by a
//                       forced PE access on the previous edge
//   vga_drop_cnt_o      saturating count of dropped VGA requests
//   pe_req_i/we_i/addr_i/wdata_i
//                       PE access; held stable until pe_gnt_o is seen
//   pe_gnt_o            combinational grant
//   pe_rdata_o/rvalid_o PE read data (0 while not valid)
//   enb_o/web_o/addrb_o/d2memb_o
//                       registered BRAM port B controls
//   mem2db_i            BRAM read data
// ---------------------------------------------------------------------------
module bram_port_arbiter #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 8,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vga_req_i,
  input  logic [ADDR_W-1:0] vga_addr_i,
  output logic [DATA_W-1:0] vga_data_o,
  output logic              vga_valid_o,
  output logic              vga_drop_o,
  output logic [15:0]       vga_drop_cnt_o,
  input  logic              pe_req_i,
  input  logic              pe_we_i,
  input  logic [ADDR_W-1:0] pe_addr_i,
  input  logic [DATA_W-1:0] pe_wdata_i,
  output logic              pe_gnt_o,
  output logic [DATA_W-1:0] pe_rdata_o,
  output logic              pe_rvalid_o,
  output logic              enb_o,
  output logic              web_o,
  output logic [ADDR_W-1:0] addrb_o,
  output logic [DATA_W-1:0] d2memb_o,
  input  logic [DATA_W-1:0] mem2db_i
);

  // Reject parameter values that would collapse the return pipeline or
  // make the starvation threshold meaningless.
  if (RD_LAT < 1 || STARVE_MAX < 1) begin : g_param_check
    $error("bram_port_arbiter: RD_LAT and STARVE_MAX must be >= 1");
  end

  logic guard_fire;
  logic vga_win;
  logic pe_win;
  logic issue_pe;
  logic [RD_LAT-1:0] pipe_valid;
  logic [RD_LAT-1:0] pipe_pe;
  logic ret_valid;
  logic ret_pe;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             drop_now;
  logic             drop_q;
  logic [15:0]      drop_cnt;

  // The guard only matters while PE is actually asking; a saturated counter
  // with no pending request must not steal a VGA slot.
  assign guard_fire = pe_req_i && (starve_cnt == CNT_W'(STARVE_MAX));
  assign drop_now   = vga_req_i && guard_fire;

  // Counts consecutive cycles in which PE asked and was refused. Any grant
  // or any cycle without a request restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (pe_req_i && !pe_gnt_o) begin
      if (starve_cnt != CNT_W'(STARVE_MAX)) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  // The drop pulse is registered so it lines up with the cycle in which the
  // forced PE access appears on the BRAM port, together with the updated
  // count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q   <= 1'b0;
      drop_cnt <= '0;
    end else begin
      drop_q <= drop_now;
      if (drop_now && drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  assign vga_drop_o     = drop_q;
  assign vga_drop_cnt_o = drop_cnt;
`else
  assign guard_fire     = 1'b0;
  assign vga_drop_o     = 1'b0;
  assign vga_drop_cnt_o = '0;
`endif

  // pe_win and vga_win are mutually exclusive: PE can only beat a VGA
  // request when the guard fires, which also suppresses vga_win.
  assign pe_win   = pe_req_i && (!vga_req_i || guard_fire);
  assign vga_win  = vga_req_i && !guard_fire;
  assign pe_gnt_o = pe_win;

  // Issue register. On idle cycles the address is held to avoid needless
  // toggling of the BRAM address bus. Write data is zeroed for every access
  // that is not a PE write. issue_pe remembers who owns the access so a read
  // can be routed back later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enb_o    <= 1'b0;
      web_o    <= 1'b0;
      addrb_o  <= '0;
      d2memb_o <= '0;
      issue_pe <= 1'b0;
    end else if (pe_win) begin
      enb_o    <= 1'b1;
      web_o    <= pe_we_i;
      addrb_o  <= pe_addr_i;
      d2memb_o <= pe_we_i ? pe_wdata_i : '0;
      issue_pe <= 1'b1;
    end else if (vga_win) begin
      enb_o    <= 1'b1;
      web_o    <= 1'b0;
      addrb_o  <= vga_addr_i;
      d2memb_o <= '0;
      issue_pe <= 1'b0;
    end else begin
      enb_o    <= 1'b0;
      web_o    <= 1'b0;
      d2memb_o <= '0;
      issue_pe <= 1'b0;
    end
  end

  // Return pipeline: one {valid, owner} entry per BRAM latency cycle, loaded
  // from the issue register. The last stage coincides with the BRAM data, so
  // returns stay in issue order without any buffering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid <= '0;
      pipe_pe    <= '0;
    end else begin
      pipe_valid[0] <= enb_o && !web_o;
      pipe_pe[0]    <= issue_pe;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_pe[i]    <= pipe_pe[i-1];
      end
    end
  end

  assign ret_valid = pipe_valid[RD_LAT-1];
  assign ret_pe    = pipe_pe[RD_LAT-1];

  assign vga_valid_o = ret_valid && !ret_pe;
  assign pe_rvalid_o = ret_valid && ret_pe;
  assign vga_data_o  = vga_valid_o ? mem2db_i : '0;
  assign pe_rdata_o  = pe_rvalid_o ? mem2db_i : '0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_port_arbiter
//
// Self-checking bench for bram_port_arbiter. Every cycle is driven through
// applyStimulus and checked by checkOutput against a transaction-level model:
// a grant decision from the priority rules, the expected port contents, and
// a queue of outstanding reads keyed by the cycle their data is due.
// Build with ARB_STARVE_GUARD_EN defined to also exercise the starvation
// guard.
// ---------------------------------------------------------------------------
module tb_bram_port_arbiter;

  localparam int ADDR_W     = 18;
  localparam int DATA_W     = 8;
  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 16;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_data;
  logic              vga_valid;
  logic              vga_drop;
  logic [15:0]       vga_drop_cnt;
  logic              pe_req;
  logic              pe_we;
  logic [ADDR_W-1:0] pe_addr;
  logic [DATA_W-1:0] pe_wdata;
  logic              pe_gnt;
  logic [DATA_W-1:0] pe_rdata;
  logic              pe_rvalid;
  logic              enb;
  logic              web;
  logic [ADDR_W-1:0] addrb;
  logic [DATA_W-1:0] d2memb;
  logic [DATA_W-1:0] mem2db;

  bram_port_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .RD_LAT(RD_LAT),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .vga_req_i(vga_req),
    .vga_addr_i(vga_addr),
    .vga_data_o(vga_data),
    .vga_valid_o(vga_valid),
    .vga_drop_o(vga_drop),
    .vga_drop_cnt_o(vga_drop_cnt),
    .pe_req_i(pe_req),
    .pe_we_i(pe_we),
    .pe_addr_i(pe_addr),
    .pe_wdata_i(pe_wdata),
    .pe_gnt_o(pe_gnt),
    .pe_rdata_o(pe_rdata),
    .pe_rvalid_o(pe_rvalid),
    .enb_o(enb),
    .web_o(web),
    .addrb_o(addrb),
    .d2memb_o(d2memb),
    .mem2db_i(mem2db)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int              cyc;
  int              starve;
  bit              m_enb;
  bit              m_web;
  bit [ADDR_W-1:0] m_addr;
  bit [DATA_W-1:0] m_d2m;
  bit              m_drop;
  int              m_drop_cnt;
  int              ret_due[$];
  bit              ret_pe[$];

  typedef struct {
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              pe_req;
    logic              pe_we;
    logic [ADDR_W-1:0] pe_addr;
    logic [DATA_W-1:0] pe_wdata;
    logic              exp_gnt;
    logic              exp_enb;
    logic              exp_web;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_d2m;
  } vec_t;

  vec_t vecs[6];

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic resetModel();
    cyc        = 0;
    starve     = 0;
    m_enb      = 1'b0;
    m_web      = 1'b0;
    m_addr     = '0;
    m_d2m      = '0;
    m_drop     = 1'b0;
    m_drop_cnt = 0;
    ret_due.delete();
    ret_pe.delete();
  endtask

  // Drives one cycle's inputs just after the falling edge and lets the
  // combinational outputs settle before anything is sampled.
  task automatic applyStimulus(input logic v, input logic [ADDR_W-1:0] va,
                               input logic p, input logic pw,
                               input logic [ADDR_W-1:0] pa,
                               input logic [DATA_W-1:0] pd,
                               input logic [DATA_W-1:0] m);
    @(negedge clk);
    vga_req  = v;
    vga_addr = va;
    pe_req   = p;
    pe_we    = pw;
    pe_addr  = pa;
    pe_wdata = pd;
    mem2db   = m;
    #1;
  endtask

  task automatic applyIdle(input logic [DATA_W-1:0] m);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, m);
  endtask

  // Compares the current cycle against the model, then advances the model
  // by the rising edge that ends this cycle.
  task automatic checkOutput();
    bit forced;
    bit gnt;
    bit exp_vv;
    bit exp_pv;
    forced = GUARD && pe_req && (starve == STARVE_MAX);
    gnt    = pe_req && (!vga_req || forced);
    exp_vv = 1'b0;
    exp_pv = 1'b0;
    if (ret_due.size() > 0 && ret_due[0] == cyc) begin
      if (ret_pe[0]) exp_pv = 1'b1;
      else           exp_vv = 1'b1;
      void'(ret_due.pop_front());
      void'(ret_pe.pop_front());
    end
    cmp("pe_gnt", 32'(pe_gnt), 32'(gnt));
    cmp("enb", 32'(enb), 32'(m_enb));
    cmp("web", 32'(web), 32'(m_web));
    cmp("addrb", 32'(addrb), 32'(m_addr));
    cmp("d2memb", 32'(d2memb), 32'(m_d2m));
    cmp("vga_drop", 32'(vga_drop), 32'(m_drop));
    cmp("vga_drop_cnt", 32'(vga_drop_cnt), 32'(m_drop_cnt));
    cmp("vga_valid", 32'(vga_valid), 32'(exp_vv));
    cmp("vga_data", 32'(vga_data), exp_vv ? 32'(mem2db) : 32'd0);
    cmp("pe_rvalid", 32'(pe_rvalid), 32'(exp_pv));
    cmp("pe_rdata", 32'(pe_rdata), exp_pv ? 32'(mem2db) : 32'd0);

    if (gnt) begin
      m_enb  = 1'b1;
      m_web  = pe_we;
      m_addr = pe_addr;
      m_d2m  = pe_we ? pe_wdata : '0;
      if (!pe_we) begin
        ret_due.push_back(cyc + 1 + RD_LAT);
        ret_pe.push_back(1'b1);
      end
    end else if (vga_req) begin
      m_enb  = 1'b1;
      m_web  = 1'b0;
      m_addr = vga_addr;
      m_d2m  = '0;
      ret_due.push_back(cyc + 1 + RD_LAT);
      ret_pe.push_back(1'b0);
    end else begin
      m_enb = 1'b0;
      m_web = 1'b0;
      m_d2m = '0;
    end
    m_drop = vga_req && forced;
    if (m_drop && m_drop_cnt < 65535) m_drop_cnt++;
    if (GUARD && pe_req && !gnt) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
    else starve = 0;
    cyc++;
  endtask

  task automatic checkAllZero(input string tag);
    cmp({tag, "_enb"}, 32'(enb), 32'd0);
    cmp({tag, "_web"}, 32'(web), 32'd0);
    cmp({tag, "_addrb"}, 32'(addrb), 32'd0);
    cmp({tag, "_d2memb"}, 32'(d2memb), 32'd0);
    cmp({tag, "_vga_valid"}, 32'(vga_valid), 32'd0);
    cmp({tag, "_vga_data"}, 32'(vga_data), 32'd0);
    cmp({tag, "_pe_rvalid"}, 32'(pe_rvalid), 32'd0);
    cmp({tag, "_pe_rdata"}, 32'(pe_rdata), 32'd0);
    cmp({tag, "_vga_drop"}, 32'(vga_drop), 32'd0);
    cmp({tag, "_drop_cnt"}, 32'(vga_drop_cnt), 32'd0);
    cmp({tag, "_pe_gnt"}, 32'(pe_gnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit              pend;
    bit              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wd;
    logic            gnt_seen;

    // Vector table: each entry is one request cycle followed by an idle
    // cycle in which the registered port contents are checked.
    vecs[0] = '{1'b1, 18'h00123, 1'b0, 1'b0, 18'h0,     8'h00, 1'b0, 1'b1, 1'b0, 18'h00123, 8'h00};
    vecs[1] = '{1'b0, 18'h0,     1'b1, 1'b1, 18'h3FFFF, 8'h5A, 1'b1, 1'b1, 1'b1, 18'h3FFFF, 8'h5A};
    vecs[2] = '{1'b0, 18'h0,     1'b1, 1'b0, 18'h00ABC, 8'h99, 1'b1, 1'b1, 1'b0, 18'h00ABC, 8'h00};
    vecs[3] = '{1'b0, 18'h0,     1'b0, 1'b0, 18'h0,     8'h00, 1'b0, 1'b0, 1'b0, 18'h00ABC, 8'h00};
    vecs[4] = '{1'b1, 18'h3FFFF, 1'b0, 1'b0, 18'h0,     8'h00, 1'b0, 1'b1, 1'b0, 18'h3FFFF, 8'h00};
    vecs[5] = '{1'b0, 18'h0,     1'b1, 1'b1, 18'h00000, 8'hFF, 1'b1, 1'b1, 1'b1, 18'h00000, 8'hFF};

    rst_n    = 1'b0;
    vga_req  = 1'b0;
    vga_addr = '0;
    pe_req   = 1'b0;
    pe_we    = 1'b0;
    pe_addr  = '0;
    pe_wdata = '0;
    mem2db   = 8'h3C;
    resetModel();
    #2;
    checkAllZero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].vga_req, vecs[i].vga_addr, vecs[i].pe_req, vecs[i].pe_we,
                    vecs[i].pe_addr, vecs[i].pe_wdata, 8'($urandom_range(0, 255)));
      cmp("tbl_gnt", 32'(pe_gnt), 32'(vecs[i].exp_gnt));
      checkOutput();
      applyIdle(8'($urandom_range(0, 255)));
      cmp("tbl_enb", 32'(enb), 32'(vecs[i].exp_enb));
      cmp("tbl_web", 32'(web), 32'(vecs[i].exp_web));
      cmp("tbl_addrb", 32'(addrb), 32'(vecs[i].exp_addr));
      cmp("tbl_d2memb", 32'(d2memb), 32'(vecs[i].exp_d2m));
      checkOutput();
    end
    repeat (4) begin applyIdle(8'h00); checkOutput(); end

    // Single VGA read, data A5 in the return cycle
    applyStimulus(1'b1, 18'h00010, 1'b0, 1'b0, '0, '0, 8'h00);
    checkOutput();
    applyIdle(8'h00);
    cmp("vga1_enb", 32'(enb), 32'd1);
    cmp("vga1_addrb", 32'(addrb), 32'h00010);
    checkOutput();
    applyIdle(8'h00);
    checkOutput();
    applyIdle(8'hA5);
    cmp("vga1_valid", 32'(vga_valid), 32'd1);
    cmp("vga1_data", 32'(vga_data), 32'hA5);
    cmp("vga1_pe_rvalid", 32'(pe_rvalid), 32'd0);
    checkOutput();
    repeat (3) begin applyIdle(8'h00); checkOutput(); end

    // Both request for 4 cycles: VGA wins each, PE granted once VGA idles
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 18'(18'h00100 + i), 1'b1, 1'b0, 18'h00555, 8'h00, 8'(i));
      cmp("both_gnt", 32'(pe_gnt), 32'd0);
      if (i > 0) cmp("both_addrb", 32'(addrb), 32'(18'h00100 + i - 1));
      checkOutput();
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 18'h00555, 8'h00, 8'h11);
    cmp("both_vga_last", 32'(addrb), 32'h00103);
    cmp("both_pe_gnt", 32'(pe_gnt), 32'd1);
    checkOutput();
    applyIdle(8'h22);
    cmp("both_pe_enb", 32'(enb), 32'd1);
    cmp("both_pe_addrb", 32'(addrb), 32'h00555);
    checkOutput();
    repeat (4) begin applyIdle(8'h00); checkOutput(); end

    // Interleaved VGA, PE, VGA reads: returns in order on consecutive cycles
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: applyStimulus(1'b1, 18'h00010, 1'b0, 1'b0, '0, '0, 8'(8'h30 + k));
        1: applyStimulus(1'b0, '0, 1'b1, 1'b0, 18'h00020, 8'h00, 8'(8'h30 + k));
        2: applyStimulus(1'b1, 18'h00030, 1'b0, 1'b0, '0, '0, 8'(8'h30 + k));
        default: applyIdle(8'(8'h30 + k));
      endcase
      if (k == 3) begin
        cmp("il_vga0_valid", 32'(vga_valid), 32'd1);
        cmp("il_vga0_data", 32'(vga_data), 32'h33);
        cmp("il_vga0_pev", 32'(pe_rvalid), 32'd0);
      end
      if (k == 4) begin
        cmp("il_pe_valid", 32'(pe_rvalid), 32'd1);
        cmp("il_pe_data", 32'(pe_rdata), 32'h34);
        cmp("il_pe_vgav", 32'(vga_valid), 32'd0);
      end
      if (k == 5) begin
        cmp("il_vga1_valid", 32'(vga_valid), 32'd1);
        cmp("il_vga1_data", 32'(vga_data), 32'h35);
      end
      checkOutput();
    end
    repeat (3) begin applyIdle(8'h00); checkOutput(); end

`ifdef ARB_STARVE_GUARD_EN
    // Continuous VGA and PE read: PE forced on the 17th request cycle
    for (int i = 1; i <= 17; i++) begin
      applyStimulus(1'b1, 18'(18'h01000 + i), 1'b1, 1'b0, 18'h2AAAA, 8'h00, 8'(i));
      cmp(i == 17 ? "grd_gnt_forced" : "grd_gnt_denied", 32'(pe_gnt), (i == 17) ? 32'd1 : 32'd0);
      checkOutput();
    end
    for (int i = 1; i <= 17; i++) begin
      applyStimulus(1'b1, 18'(18'h02000 + i), 1'b1, 1'b0, 18'h2AAAA, 8'h00, 8'(i));
      if (i == 1) begin
        cmp("grd_drop", 32'(vga_drop), 32'd1);
        cmp("grd_drop_cnt", 32'(vga_drop_cnt), 32'd1);
        cmp("grd_enb", 32'(enb), 32'd1);
        cmp("grd_addrb", 32'(addrb), 32'h2AAAA);
      end
      cmp(i == 17 ? "grd2_gnt_forced" : "grd2_gnt_denied", 32'(pe_gnt), (i == 17) ? 32'd1 : 32'd0);
      checkOutput();
    end
    applyIdle(8'h00);
    cmp("grd_drop_cnt2", 32'(vga_drop_cnt), 32'd2);
    checkOutput();
    repeat (4) begin applyIdle(8'h00); checkOutput(); end
`endif

    // Randomized traffic with PE holding its request until granted
    pend   = 1'b0;
    r_we   = 1'b0;
    r_addr = '0;
    r_wd   = '0;
    for (int n = 0; n < 400; n++) begin
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend   = 1'b1;
        r_we   = 1'($urandom_range(0, 1));
        r_addr = 18'($urandom_range(0, 18'h3FFFF));
        r_wd   = 8'($urandom_range(0, 255));
      end
      applyStimulus($urandom_range(0, 9) < 9, 18'($urandom_range(0, 18'h3FFFF)),
                    pend, r_we, r_addr, r_wd, 8'($urandom_range(0, 255)));
      gnt_seen = pe_gnt;
      checkOutput();
      if (pend && gnt_seen) pend = 1'b0;
    end
    repeat (4) begin applyIdle(8'h00); checkOutput(); end

    // Reset one cycle after a VGA read issues: outputs clear at once and the
    // read never returns
    applyStimulus(1'b1, 18'h00042, 1'b0, 1'b0, '0, '0, 8'h00);
    checkOutput();
    applyIdle(8'h77);
    cmp("mid_enb_before", 32'(enb), 32'd1);
    checkOutput();
    #1;
    rst_n = 1'b0;
    #1;
    checkAllZero("midrst");
    resetModel();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyIdle(8'h77);
      cmp("midrst_no_valid", 32'(vga_valid), 32'd0);
      checkOutput();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
